// File: rtl/seq_detect_ctrl.sv
// Configurable serial pattern detector with an IDLE/RUN/DONE run controller.
// A pattern of 1..MAX_LEN bits is loaded through a valid/ready handshake in
// IDLE; a run then counts matches on the x stream until a threshold is
// reached or stop is asserted. y is a registered one-cycle match pulse.
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_thresh,
  input  logic               start,
  input  logic               stop,
  input  logic               x,
  input  logic               x_valid,
  output logic               y,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_reg, state_next;
  logic [MAX_LEN-1:0] pat_reg,   pat_next;
  logic [LEN_W-1:0]   len_reg,   len_next;
  logic               ovl_reg,   ovl_next;
  logic [CNT_W-1:0]   thr_reg,   thr_next;
  logic [MAX_LEN-1:0] hist_reg,  hist_next;
  logic [LEN_W-1:0]   fill_reg,  fill_next;
  logic               y_reg,     y_next;
  logic [CNT_W-1:0]   cnt_reg,   cnt_next;
  logic               err_reg,   err_next;

  // Helper values for the bit arriving this cycle
  logic [MAX_LEN-1:0] len_mask;
  logic [MAX_LEN-1:0] hist_shift;
  logic [LEN_W-1:0]   fill_inc;
  logic [CNT_W-1:0]   cnt_inc;
  logic               hit;
  logic               cfg_len_ok;

  // Only the low len bits of history and pattern take part in the compare
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
    assign len_mask[gi] = (LEN_W'(gi) < len_reg);
  end

  assign hist_shift = {hist_reg[MAX_LEN-2:0], x};
  assign fill_inc   = (fill_reg == LEN_W'(MAX_LEN)) ? fill_reg : fill_reg + LEN_W'(1);
  assign cnt_inc    = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + CNT_W'(1);
  assign hit        = x_valid && (fill_inc >= len_reg) &&
                      (((hist_shift ^ pat_reg) & len_mask) == '0);
  assign cfg_len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

  // Next-state logic for controller, config store, history and counters
  always_comb begin
    state_next = state_reg;
    pat_next   = pat_reg;
    len_next   = len_reg;
    ovl_next   = ovl_reg;
    thr_next   = thr_reg;
    hist_next  = hist_reg;
    fill_next  = fill_reg;
    y_next     = 1'b0;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    case (state_reg)
      S_IDLE: begin
        // A config offer wins over a simultaneous start
        if (cfg_valid) begin
          if (cfg_len_ok) begin
            pat_next = cfg_pattern;
            len_next = cfg_len;
            ovl_next = cfg_overlap;
            thr_next = cfg_thresh;
            err_next = 1'b0;
          end else begin
            err_next = 1'b1;
          end
        end else if (start) begin
          if (len_reg != '0) begin
            state_next = S_RUN;
            hist_next  = '0;
            fill_next  = '0;
            cnt_next   = '0;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (x_valid) begin
          hist_next = hist_shift;
          fill_next = fill_inc;
          if (hit) begin
            y_next   = 1'b1;
            cnt_next = cnt_inc;
            // Non-overlapping mode needs len fresh bits before the next match
            if (!ovl_reg) fill_next = '0;
            if ((thr_reg != '0) && (cnt_inc == thr_reg)) state_next = S_DONE;
          end
        end
        if (stop) state_next = S_DONE;
      end
      S_DONE: begin
        if (stop) begin
          state_next = S_IDLE;
        end else if (start) begin
          state_next = S_RUN;
          hist_next  = '0;
          fill_next  = '0;
          cnt_next   = '0;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State registers; reset forces IDLE and invalidates the stored config
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      pat_reg   <= '0;
      len_reg   <= '0;
      ovl_reg   <= 1'b0;
      thr_reg   <= '0;
      hist_reg  <= '0;
      fill_reg  <= '0;
      y_reg     <= 1'b0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pat_reg   <= pat_next;
      len_reg   <= len_next;
      ovl_reg   <= ovl_next;
      thr_reg   <= thr_next;
      hist_reg  <= hist_next;
      fill_reg  <= fill_next;
      y_reg     <= y_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  assign cfg_ready = (state_reg == S_IDLE);
  assign busy      = (state_reg == S_RUN);
  assign done      = (state_reg == S_DONE);
  assign y         = y_reg;
  assign match_cnt = cnt_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: directed scenarios followed by a random phase,
// every cycle checked against a queue-based behavioural model.
module tb_seq_detect_ctrl;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int LEN_W   = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic [CNT_W-1:0]   cfg_thresh = '0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               x = 1'b0;
  logic               x_valid = 1'b0;
  logic               y;
  logic [CNT_W-1:0]   match_cnt;
  logic               busy;
  logic               done;
  logic               err;

  int total = 0;
  int bad   = 0;

  seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_thresh(cfg_thresh),
    .start(start), .stop(stop), .x(x), .x_valid(x_valid),
    .y(y), .match_cnt(match_cnt), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0 = idle, 1 = running, 2 = finished
  int                 m_mode;
  int                 m_len;
  logic [MAX_LEN-1:0] m_pat;
  bit                 m_ovl;
  int                 m_thr;
  bit                 m_err;
  int                 m_cnt;
  bit                 m_y;
  bit                 bits_q[$];

  function automatic bit tail_matches();
    int n = bits_q.size();
    if (n < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++)
      if (bits_q[n - m_len + i] != m_pat[m_len - 1 - i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_len = 0; m_pat = '0; m_ovl = 0; m_thr = 0;
    m_err = 0; m_cnt = 0; m_y = 0; bits_q.delete();
  endtask

  task automatic model_step();
    bit ny = 1'b0;
    case (m_mode)
      0: begin
        if (cfg_valid) begin
          if (cfg_len >= 1 && cfg_len <= MAX_LEN) begin
            m_pat = cfg_pattern; m_len = int'(cfg_len);
            m_ovl = cfg_overlap; m_thr = int'(cfg_thresh); m_err = 0;
          end else m_err = 1;
        end else if (start) begin
          if (m_len != 0) begin m_mode = 1; bits_q.delete(); m_cnt = 0; end
          else m_err = 1;
        end
      end
      1: begin
        if (x_valid) begin
          bits_q.push_back(x);
          if (bits_q.size() > MAX_LEN) void'(bits_q.pop_front());
          if (tail_matches()) begin
            ny = 1'b1;
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (!m_ovl) bits_q.delete();
            if (m_thr != 0 && m_cnt == m_thr) m_mode = 2;
          end
        end
        if (stop) m_mode = 2;
      end
      default: begin
        if (stop) m_mode = 0;
        else if (start) begin m_mode = 1; bits_q.delete(); m_cnt = 0; end
      end
    endcase
    m_y = ny;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".y"},         32'(y),         32'(m_y));
    chk({tag, ".match_cnt"}, 32'(match_cnt), 32'(m_cnt));
    chk({tag, ".busy"},      32'(busy),      32'(m_mode == 1));
    chk({tag, ".done"},      32'(done),      32'(m_mode == 2));
    chk({tag, ".err"},       32'(err),       32'(m_err));
    chk({tag, ".cfg_ready"}, 32'(cfg_ready), 32'(m_mode == 0));
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    #1;
    model_step();
    check_all(tag);
  endtask

  task automatic do_cfg(input logic [7:0] p, input int l, input bit o, input int t);
    cfg_pattern = p; cfg_len = LEN_W'(l); cfg_overlap = o; cfg_thresh = CNT_W'(t);
    cfg_valid = 1'b1; cyc("cfg"); cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; cyc("start"); start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1; cyc("stop"); stop = 1'b0;
  endtask

  task automatic send_bit(input bit b);
    x = b; x_valid = 1'b1; cyc("bit"); x_valid = 1'b0;
  endtask

  task automatic to_idle();
    if (m_mode == 1) do_stop();
    if (m_mode == 2) do_stop();
  endtask

  task automatic send_1000();
    send_bit(1); send_bit(0); send_bit(0); send_bit(0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b1;

    // Two non-overlapping matches of 1000
    do_cfg(8'b1000, 4, 0, 0);
    do_start();
    send_bit(1); send_bit(0); send_bit(0); send_bit(0);
    chk("r037_y4", 32'(y), 32'd1);
    send_bit(1);
    chk("r037_y5", 32'(y), 32'd0);
    send_bit(0); send_bit(0); send_bit(0);
    chk("r037_y8", 32'(y), 32'd1);
    chk("r037_cnt", 32'(match_cnt), 32'd2);
    $display("scenario pattern1000 cnt=%0d", match_cnt);
    to_idle();

    // 101 on 10101 with and without overlap
    do_cfg(8'b101, 3, 1, 0);
    do_start();
    send_bit(1); send_bit(0); send_bit(1); send_bit(0); send_bit(1);
    chk("r038_ovl1", 32'(match_cnt), 32'd2);
    to_idle();
    do_cfg(8'b101, 3, 0, 0);
    do_start();
    send_bit(1); send_bit(0); send_bit(1); send_bit(0); send_bit(1);
    chk("r038_ovl0", 32'(match_cnt), 32'd1);
    $display("scenario overlap cnt=%0d", match_cnt);
    to_idle();

    // Threshold of one ends the run at the first match
    do_cfg(8'b1000, 4, 0, 1);
    do_start();
    send_1000();
    chk("r039_done", 32'(done), 32'd1);
    chk("r039_cnt4", 32'(match_cnt), 32'd1);
    send_1000();
    chk("r039_y", 32'(y), 32'd0);
    chk("r039_cnt8", 32'(match_cnt), 32'd1);
    $display("scenario thresh done=%0d", done);
    to_idle();

    // Gaps in x_valid, then asynchronous reset in the middle of a run
    do_cfg(8'b1000, 4, 0, 0);
    do_start();
    for (int i = 0; i < 4; i++) begin
      send_bit(i == 0);
      x = 1'b1; cyc("gap"); cyc("gap");
    end
    chk("r041_cnt", 32'(match_cnt), 32'd1);
    send_bit(1); send_bit(0);
    #2 rst = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    chk("r041_ready", 32'(cfg_ready), 32'd1);
    chk("r041_cnt0", 32'(match_cnt), 32'd0);
    cyc("in_rst");
    rst = 1'b1;
    $display("scenario gaps+reset ready=%0d", cfg_ready);

    // Bad length and start without config
    do_cfg(8'b1, 0, 0, 0);
    chk("r040_err_len", 32'(err), 32'd1);
    do_start();
    chk("r040_err_start", 32'(err), 32'd1);
    chk("r040_busy", 32'(busy), 32'd0);
    do_cfg(8'b1000, 4, 0, 0);
    chk("r040_err_clr", 32'(err), 32'd0);
    $display("scenario cfg err=%0d", err);

    // Stop coincident with a completing match; config offer in DONE
    do_start();
    send_bit(1); send_bit(0); send_bit(0);
    x = 1'b0; x_valid = 1'b1; stop = 1'b1;
    cyc("stop_match");
    x_valid = 1'b0; stop = 1'b0;
    chk("r042_y", 32'(y), 32'd1);
    chk("r042_cnt", 32'(match_cnt), 32'd1);
    chk("r042_done", 32'(done), 32'd1);
    cfg_pattern = 8'b1111; cfg_len = 4'd4; cfg_valid = 1'b1;
    #1 chk("r042_ready", 32'(cfg_ready), 32'd0);
    cyc("cfg_in_done");
    cfg_valid = 1'b0;
    do_start();
    send_1000();
    chk("r042_cfg_kept", 32'(match_cnt), 32'd1);
    $display("scenario stop+match cnt=%0d", match_cnt);
    to_idle();

    // Random phase: all inputs random, biased towards short patterns
    for (int i = 0; i < 3000; i++) begin
      cfg_valid   = ($urandom_range(0, 39) == 0);
      cfg_pattern = MAX_LEN'($urandom);
      cfg_len     = ($urandom_range(0, 3) == 0) ? LEN_W'($urandom_range(0, 9))
                                                : LEN_W'($urandom_range(1, 3));
      cfg_overlap = 1'($urandom_range(0, 1));
      cfg_thresh  = CNT_W'($urandom_range(0, 4));
      start       = ($urandom_range(0, 19) == 0);
      stop        = ($urandom_range(0, 59) == 0);
      x_valid     = ($urandom_range(0, 3) != 0);
      x           = 1'($urandom_range(0, 1));
      cyc("rand");
      if (m_y) $display("rand match cyc=%0d cnt=%0d len=%0d", i, m_cnt, m_len);
    end
    cfg_valid = 1'b0; start = 1'b0; stop = 1'b0; x_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, max pattern length in bits (2..16).
REQ-002 SHALL have parameter CNT_W, default 8, width of match counter and threshold.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_valid  input  1  configuration offer.
REQ-006 SHALL have port cfg_ready  output  1  controller accepts configuration (high only in IDLE).
REQ-007 SHALL have port cfg_pattern  input  MAX_LEN  pattern; bit cfg_len-1 = first bit received, bit 0 = last.
REQ-008 SHALL have port cfg_len  input  $clog2(MAX_LEN+1)  pattern length.
REQ-009 SHALL have port cfg_overlap  input  1  1 = overlapping matches allowed.
REQ-010 SHALL have port cfg_thresh  input  CNT_W  match count ending the run; 0 = run until stop.
REQ-011 SHALL have port start  input  1  begin detection (IDLE->RUN).
REQ-012 SHALL have port stop  input  1  abort run (RUN->DONE).
REQ-013 SHALL have port x  input  1  serial data bit.
REQ-014 SHALL have port x_valid  input  1  x sampled only when high.
REQ-015 SHALL have port y  output  1  registered Moore match pulse.
REQ-016 SHALL have port match_cnt  output  CNT_W  matches in current run.
REQ-017 SHALL have port busy  output  1  high in RUN.
REQ-018 SHALL have port done  output  1  high in DONE.
REQ-019 SHALL have port err  output  1  sticky config error flag.

Function
REQ-020 SHALL implement FSM states IDLE, RUN, DONE; encoding free.
REQ-021 IDLE: cfg_valid & cfg_ready SHALL latch pattern, len, overlap, thresh in same edge; err cleared if cfg_len in 1..MAX_LEN, else err set, config not latched.
REQ-022 IDLE: start with valid latched config SHALL go RUN, clearing history, fill count, match_cnt; start without valid config SHALL set err and stay IDLE.
REQ-023 cfg_valid and start in same cycle: config accepted first, start ignored that cycle.
REQ-024 RUN: each x_valid cycle SHALL shift x into history LSB and increment fill count (saturating at MAX_LEN).
REQ-025 Match SHALL be declared on an edge where fill count (incl. new bit) >= len and last len bits equal pattern[len-1:0].
REQ-026 On match: y SHALL be high for exactly the one cycle after that edge; match_cnt SHALL increment (saturating at all-ones) on the same edge.
REQ-027 cfg_overlap=0: fill count SHALL reset to 0 on match; cfg_overlap=1: history and fill count retained.
REQ-028 x_valid low SHALL hold history, fill count, y=0.
REQ-029 Match with thresh!=0 and new match_cnt==thresh SHALL go DONE on that edge.
REQ-030 stop in RUN SHALL go DONE next edge; stop and match same edge: match counted, then DONE.
REQ-031 DONE: x ignored, y=0, match_cnt held; start SHALL go RUN (new run, same config); cfg_valid SHALL be ignored until return to IDLE.
REQ-032 DONE: stop SHALL return to IDLE, match_cnt held until next start.
REQ-033 cfg_ready SHALL be 0 outside IDLE.
REQ-034 start in RUN SHALL be ignored.

Reset
REQ-035 rst low SHALL immediately force IDLE, y=0, match_cnt=0, busy=0, done=0, err=0, cfg_ready=1, config cleared to invalid (len=0), regardless of clock.
REQ-036 Reset mid-run SHALL discard history; first edge after release operates in IDLE.

Verification
REQ-037 Cfg pattern=4'b1000 len=4 overlap=0 thresh=0, start, x=1,0,0,0,1,0,0,0 -> y pulses after 4th and 8th bit, match_cnt=2.
REQ-038 Pattern 3'b101 len=3, x=1,0,1,0,1: overlap=1 -> match_cnt=2; overlap=0 -> match_cnt=1.
REQ-039 Pattern 1000, thresh=1, stream 1,0,0,0,1,0,0,0 -> DONE after 4th bit, done=1, match_cnt stays 1, no second y.
REQ-040 cfg_len=0 -> err=1, state IDLE; start -> err=1, busy=0; then valid cfg -> err=0.
REQ-041 x_valid gaps inserted between bits of 1000 -> same single match; rst low mid-stream -> all outputs reset at once, cfg_ready=1.
REQ-042 stop coincident with completing match -> match_cnt incremented, y pulses, done=1 next cycle; cfg_valid in DONE -> cfg_ready=0, config unchanged.
